// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite subordinate terminating on a bank of NUM_REGS software-visible registers.
// Independent one-deep AW/W buffers feed a single commit point; reads return registered data.
module axi4_lite_reg_slave #(
    parameter int A        = 8,
    parameter int N        = 4,
    parameter int NUM_REGS = 16,
    parameter int USE_STRB = 1
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [A-1:0]               awaddr,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [8*N-1:0]             wdata,
    input  logic [N-1:0]               wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [A-1:0]               araddr,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [8*N-1:0]             rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [NUM_REGS*8*N-1:0]    reg_q,
    output logic [NUM_REGS-1:0]        wr_pulse
);

    localparam int DW = 8 * N;
    localparam int BW = $clog2(N);
    localparam int IW = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Any set bit above the register index field means the access misses the bank.
    function automatic logic addr_in_range(input logic [A-1:0] addr);
        return (addr >> (BW + IW)) == '0;
    endfunction

    logic                           aw_full_q, aw_full_d;
    logic [A-1:0]                   aw_addr_q, aw_addr_d;
    logic                           w_full_q, w_full_d;
    logic [DW-1:0]                  w_data_q, w_data_d;
    logic [N-1:0]                   w_strb_q, w_strb_d;
    logic                           bvalid_q, bvalid_d;
    logic [1:0]                     bresp_q, bresp_d;
    logic                           rvalid_q, rvalid_d;
    logic [DW-1:0]                  rdata_q, rdata_d;
    logic [1:0]                     rresp_q, rresp_d;
    logic [NUM_REGS-1:0][DW-1:0]    regs_q, regs_d;
    logic [NUM_REGS-1:0]            wr_pulse_q, wr_pulse_d;

    logic          aw_hs;
    logic          w_hs;
    logic          ar_hs;
    logic          commit;
    logic [IW-1:0] widx;
    logic [IW-1:0] ridx;

    assign awready  = !aw_full_q && !areset;
    assign wready   = !w_full_q && !areset;
    assign arready  = !rvalid_q && !areset;
    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;
    assign reg_q    = regs_q;
    assign wr_pulse = wr_pulse_q;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign commit = aw_full_q && w_full_q && !bvalid_q;
    assign widx   = aw_addr_q[BW +: IW];
    assign ridx   = araddr[BW +: IW];

    always_comb begin
        aw_full_d  = aw_full_q;
        aw_addr_d  = aw_addr_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end

        // Handshakes cannot coincide with a commit: both buffers must already be full.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (addr_in_range(aw_addr_q)) begin
                bresp_d          = RESP_OKAY;
                wr_pulse_d[widx] = 1'b1;
                for (int k = 0; k < N; k++) begin
                    if (USE_STRB == 0 || w_strb_q[k]) begin
                        regs_d[widx][8*k +: 8] = w_data_q[8*k +: 8];
                    end
                end
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end

        // Reads sample regs_q, so a same-edge write is not yet visible.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (addr_in_range(araddr)) begin
                rdata_d = regs_q[ridx];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            regs_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            aw_full_q  <= aw_full_d;
            aw_addr_q  <= aw_addr_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed and randomized checks of axi4_lite_reg_slave against a register-array model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi4_lite_reg_slave;

    localparam int A  = 8;
    localparam int N  = 4;
    localparam int NR = 16;
    localparam int DW = 32;

    logic                 aclk;
    logic                 areset;
    logic [A-1:0]         awaddr;
    logic                 awvalid;
    logic                 awready;
    logic [DW-1:0]        wdata;
    logic [N-1:0]         wstrb;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic [A-1:0]         araddr;
    logic                 arvalid;
    logic                 arready;
    logic [DW-1:0]        rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;
    logic [NR*DW-1:0]     reg_q;
    logic [NR-1:0]        wr_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] model_regs [NR];

    axi4_lite_reg_slave #(.A(A), .N(N), .NUM_REGS(NR), .USE_STRB(1)) dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_q(reg_q), .wr_pulse(wr_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic bit model_in_range(input logic [7:0] a);
        return int'(a) < NR * N;
    endfunction

    function automatic int model_idx(input logic [7:0] a);
        return (int'(a) / N) % NR;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp, output logic [31:0] pulse);
        logic [31:0] v;
        resp  = 2'b10;
        pulse = 32'h0;
        if (model_in_range(a)) begin
            v = model_regs[model_idx(a)];
            for (int k = 0; k < N; k++) begin
                if (s[k]) v = (v & ~(32'hFF << (8 * k))) | (d & (32'hFF << (8 * k)));
            end
            model_regs[model_idx(a)] = v;
            resp  = 2'b00;
            pulse = 32'h1 << model_idx(a);
        end
    endtask

    task automatic model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        d    = model_in_range(a) ? model_regs[model_idx(a)] : 32'h0;
        resp = model_in_range(a) ? 2'b00 : 2'b10;
    endtask

    task automatic applyStimulus(input bit aw_en, input logic [7:0] aw_a,
                                 input bit w_en, input logic [31:0] w_d, input logic [3:0] w_s);
        awvalid = aw_en;
        wvalid  = w_en;
        if (aw_en) awaddr = aw_a;
        if (w_en) begin
            wdata = w_d;
            wstrb = w_s;
        end
    endtask

    task automatic step();
        @(negedge aclk);
    endtask

    task automatic checkAllRegs(input string tag);
        for (int i = 0; i < NR; i++) checkOutput(tag, reg_q[i*DW +: DW], model_regs[i]);
    endtask

    // Full write transaction with bready held high; collects any wr_pulse seen on the way.
    task automatic axiWrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [31:0] pulses);
        bit aw_hs;
        bit w_hs;
        bit got;
        got    = 1'b0;
        resp   = 2'b11;
        pulses = 32'h0;
        applyStimulus(1'b1, a, 1'b1, d, s);
        bready = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            if (bvalid) begin
                resp = bresp;
                got  = 1'b1;
            end
            pulses = pulses | 32'(wr_pulse);
            step();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
        end
        pulses  = pulses | 32'(wr_pulse);
        bready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!got) checkOutput("write_timeout", 32'h0, 32'h1);
    endtask

    task automatic axiRead(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit ar_hs;
        bit got;
        got     = 1'b0;
        d       = 32'hFFFF_FFFF;
        resp    = 2'b11;
        araddr  = a;
        arvalid = 1'b1;
        rready  = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            ar_hs = arvalid && arready;
            if (rvalid) begin
                d    = rdata;
                resp = rresp;
                got  = 1'b1;
            end
            step();
            if (ar_hs) arvalid = 1'b0;
        end
        arvalid = 1'b0;
        rready  = 1'b0;
        if (!got) checkOutput("read_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [1:0]  exp_resp;
        logic [31:0] pulses;
        logic [31:0] exp_pulse;
        logic [31:0] rd;
        logic [31:0] exp_d;
        logic [31:0] old_val;
        logic [7:0]  a;

        areset  = 1'b1;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        for (int i = 0; i < NR; i++) model_regs[i] = 32'h0;

        // Reset state
        repeat (3) step();
        checkOutput("rst_awready", 32'(awready), 32'h0);
        checkOutput("rst_wready", 32'(wready), 32'h0);
        checkOutput("rst_arready", 32'(arready), 32'h0);
        checkOutput("rst_bvalid", 32'(bvalid), 32'h0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'h0);
        checkOutput("rst_reg_q", 32'(|reg_q), 32'h0);
        checkOutput("rst_wr_pulse", 32'(wr_pulse), 32'h0);
        areset = 1'b0;
        step();
        checkOutput("idle_awready", 32'(awready), 32'h1);
        checkOutput("idle_wready", 32'(wready), 32'h1);
        checkOutput("idle_arready", 32'(arready), 32'h1);

        // AW and W in the same cycle: bvalid after two edges
        $display("[TB] same-cycle AW+W write");
        applyStimulus(1'b1, 8'h04, 1'b1, 32'hDEAD_BEEF, 4'hF);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
        checkOutput("t1_bvalid_early", 32'(bvalid), 32'h0);
        checkOutput("t1_awready_full", 32'(awready), 32'h0);
        checkOutput("t1_wready_full", 32'(wready), 32'h0);
        step();
        model_write(8'h04, 32'hDEAD_BEEF, 4'hF, exp_resp, exp_pulse);
        checkOutput("t1_bvalid", 32'(bvalid), 32'h1);
        checkOutput("t1_bresp", 32'(bresp), 32'(exp_resp));
        checkOutput("t1_reg1", reg_q[1*DW +: DW], 32'hDEAD_BEEF);
        checkOutput("t1_pulse", 32'(wr_pulse), exp_pulse);
        bready = 1'b1;
        step();
        bready = 1'b0;
        checkOutput("t1_bvalid_done", 32'(bvalid), 32'h0);
        checkOutput("t1_pulse_done", 32'(wr_pulse), 32'h0);

        // W arrives three cycles before AW; strobed merge
        $display("[TB] W-first strobed write");
        applyStimulus(1'b0, 8'h00, 1'b1, 32'h1122_3344, 4'b0101);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("t2_wready_hold", 32'(wready), 32'h0);
            checkOutput("t2_bvalid_idle", 32'(bvalid), 32'h0);
            if (c < 2) step();
        end
        applyStimulus(1'b1, 8'h04, 1'b0, 32'h0, 4'h0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
        checkOutput("t2_bvalid_early", 32'(bvalid), 32'h0);
        checkOutput("t2_wready_pre", 32'(wready), 32'h0);
        step();
        model_write(8'h04, 32'h1122_3344, 4'b0101, exp_resp, exp_pulse);
        checkOutput("t2_bvalid", 32'(bvalid), 32'h1);
        checkOutput("t2_reg1", reg_q[1*DW +: DW], 32'hDE22_BE44);
        checkOutput("t2_reg1_model", reg_q[1*DW +: DW], model_regs[1]);
        checkOutput("t2_wready_free", 32'(wready), 32'h1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        checkOutput("t2_bvalid_done", 32'(bvalid), 32'h0);

        // Out-of-range write and read
        $display("[TB] out-of-range access");
        axiWrite(8'h40, 32'hCAFE_F00D, 4'hF, resp, pulses);
        model_write(8'h40, 32'hCAFE_F00D, 4'hF, exp_resp, exp_pulse);
        checkOutput("t3_bresp", 32'(resp), 32'(exp_resp));
        checkOutput("t3_bresp_slverr", 32'(resp), 32'h2);
        checkOutput("t3_pulse", pulses, exp_pulse);
        checkAllRegs("t3_regs");
        axiRead(8'h40, rd, resp);
        checkOutput("t3_rresp", 32'(resp), 32'h2);
        checkOutput("t3_rdata", rd, 32'h0);

        // B backpressure with a second write queued behind it
        $display("[TB] B backpressure");
        applyStimulus(1'b1, 8'h0C, 1'b1, 32'hA5A5_0001, 4'hF);
        bready = 1'b0;
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
        step();
        model_write(8'h0C, 32'hA5A5_0001, 4'hF, exp_resp, exp_pulse);
        checkOutput("t4_bvalid1", 32'(bvalid), 32'h1);
        applyStimulus(1'b1, 8'h10, 1'b1, 32'h5A5A_0002, 4'hF);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
        for (int c = 0; c < 4; c++) begin
            checkOutput("t4_awready_hold", 32'(awready), 32'h0);
            checkOutput("t4_wready_hold", 32'(wready), 32'h0);
            checkOutput("t4_bvalid_hold", 32'(bvalid), 32'h1);
            checkOutput("t4_bresp_hold", 32'(bresp), 32'h0);
            checkOutput("t4_reg4_old", reg_q[4*DW +: DW], model_regs[4]);
            step();
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        checkOutput("t4_bvalid_gap", 32'(bvalid), 32'h0);
        step();
        model_write(8'h10, 32'h5A5A_0002, 4'hF, exp_resp, exp_pulse);
        checkOutput("t4_bvalid2", 32'(bvalid), 32'h1);
        checkOutput("t4_reg4_new", reg_q[4*DW +: DW], model_regs[4]);
        checkOutput("t4_pulse2", 32'(wr_pulse), exp_pulse);
        bready = 1'b1;
        step();
        bready = 1'b0;
        checkOutput("t4_bvalid_done", 32'(bvalid), 32'h0);

        // R backpressure; write committing on the AR edge is not visible to that read
        $display("[TB] R backpressure and same-edge write");
        axiWrite(8'h08, 32'h0BAD_CAFE, 4'hF, resp, pulses);
        model_write(8'h08, 32'h0BAD_CAFE, 4'hF, exp_resp, exp_pulse);
        checkOutput("t5_prewrite_bresp", 32'(resp), 32'(exp_resp));
        old_val = model_regs[2];
        applyStimulus(1'b1, 8'h08, 1'b1, 32'h1357_9BDF, 4'hF);
        bready = 1'b1;
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
        araddr  = 8'h08;
        arvalid = 1'b1;
        rready  = 1'b0;
        step();
        arvalid = 1'b0;
        model_write(8'h08, 32'h1357_9BDF, 4'hF, exp_resp, exp_pulse);
        checkOutput("t5_bvalid", 32'(bvalid), 32'h1);
        checkOutput("t5_reg2_new", reg_q[2*DW +: DW], model_regs[2]);
        for (int c = 0; c < 4; c++) begin
            checkOutput("t5_rvalid_hold", 32'(rvalid), 32'h1);
            checkOutput("t5_rdata_old", rdata, old_val);
            checkOutput("t5_rresp_hold", 32'(rresp), 32'h0);
            checkOutput("t5_arready_hold", 32'(arready), 32'h0);
            step();
        end
        bready = 1'b0;
        rready = 1'b1;
        step();
        rready = 1'b0;
        checkOutput("t5_rvalid_done", 32'(rvalid), 32'h0);
        checkOutput("t5_arready_free", 32'(arready), 32'h1);
        axiRead(8'h08, rd, resp);
        model_read(8'h08, exp_d, exp_resp);
        checkOutput("t5_readback", rd, exp_d);

        // Reset with AW buffered and a read response pending
        $display("[TB] reset mid-transaction");
        applyStimulus(1'b1, 8'h14, 1'b0, 32'h0, 4'h0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
        checkOutput("t6_aw_buffered", 32'(awready), 32'h0);
        araddr  = 8'h00;
        arvalid = 1'b1;
        rready  = 1'b0;
        step();
        arvalid = 1'b0;
        checkOutput("t6_rvalid_pending", 32'(rvalid), 32'h1);
        areset = 1'b1;
        step();
        for (int i = 0; i < NR; i++) model_regs[i] = 32'h0;
        checkOutput("t6_awready", 32'(awready), 32'h0);
        checkOutput("t6_wready", 32'(wready), 32'h0);
        checkOutput("t6_arready", 32'(arready), 32'h0);
        checkOutput("t6_bvalid", 32'(bvalid), 32'h0);
        checkOutput("t6_bresp", 32'(bresp), 32'h0);
        checkOutput("t6_rvalid", 32'(rvalid), 32'h0);
        checkOutput("t6_rdata", rdata, 32'h0);
        checkOutput("t6_rresp", 32'(rresp), 32'h0);
        checkOutput("t6_reg_q", 32'(|reg_q), 32'h0);
        checkOutput("t6_wr_pulse", 32'(wr_pulse), 32'h0);
        areset = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1, 32'h600D_F00D, 4'hF);
        bready = 1'b1;
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("t6_no_stale_b", 32'(bvalid), 32'h0);
            step();
        end
        checkOutput("t6_aw_dropped", 32'(awready), 32'h1);
        applyStimulus(1'b1, 8'h14, 1'b0, 32'h0, 4'h0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
        step();
        model_write(8'h14, 32'h600D_F00D, 4'hF, exp_resp, exp_pulse);
        checkOutput("t6_post_bvalid", 32'(bvalid), 32'h1);
        checkOutput("t6_post_bresp", 32'(bresp), 32'(exp_resp));
        checkOutput("t6_post_reg5", reg_q[5*DW +: DW], model_regs[5]);
        step();
        bready = 1'b0;
        axiWrite(8'h18, 32'h0102_0304, 4'hF, resp, pulses);
        model_write(8'h18, 32'h0102_0304, 4'hF, exp_resp, exp_pulse);
        checkOutput("t6_post_write", 32'(resp), 32'(exp_resp));
        checkAllRegs("t6_regs");

        // Randomized traffic against the model
        $display("[TB] randomized traffic");
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom_range(0, 8'h4F));
            if ($urandom_range(0, 1) == 1) begin
                exp_d = $urandom;
                axiWrite(a, exp_d, 4'($urandom_range(0, 15)), resp, pulses);
                model_write(a, exp_d, wstrb, exp_resp, exp_pulse);
                checkOutput("rnd_bresp", 32'(resp), 32'(exp_resp));
                checkOutput("rnd_pulse", pulses, exp_pulse);
            end else begin
                axiRead(a, rd, resp);
                model_read(a, exp_d, exp_resp);
                checkOutput("rnd_rdata", rd, exp_d);
                checkOutput("rnd_rresp", 32'(resp), 32'(exp_resp));
            end
        end
        checkAllRegs("final_regs");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
